alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single register file + ALU pair between N_REQ requesters
//  (calculator FSM, host/debug port, ...). Latches one request, drives RF read/write addresses and ALU
//  mode select, waits EXEC_CYCLES for the ALU result, writes it back, then pulses done to the winner.
// PARAMETERS
//  N_REQ        2   number of requesters (2..4)
//  EXEC_CYCLES  1   ALU cycles from MS_out valid to result valid (1..7)
// PORTS
//  CLK       in   1        clock, rising edge
//  RSTn      in   1        asynchronous active-low reset
//  req       in   N_REQ    request per requester; held high until own done/err
//  op        in   3*N_REQ  ALU mode per requester: 001 add, 010 sub, 011 mul, 100 xor
//  ra, rb    in   3*N_REQ  source register indices per requester
//  rw        in   3*N_REQ  destination register index per requester
//  gnt       out  N_REQ    one-hot grant, high from accept through done cycle
//  done      out  N_REQ    one-cycle pulse: result written to RF
//  err       out  N_REQ    one-cycle pulse: op rejected (illegal code), nothing written
//  busy      out  1        high whenever state != IDLE
//  num_R1    out  3        RF read port 1 address
//  num_R2    out  3        RF read port 2 address
//  W1        out  3        RF write address
//  WE        out  1        RF write enable
//  MS_out    out  3        ALU mode select
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ptr=0, gnt=0, done=0, err=0, busy=0, num_R1=num_R2=W1=3'b111,
//   WE=0, MS_out=3'b000. Same bus values in IDLE.
//  FSM: IDLE -> EXEC -> WB -> RESP -> IDLE; IDLE -> RESP on illegal op.
//  IDLE: arbitrate among req; winner = first set bit searching from ptr upward, wrapping. Latch winner
//   index, op, ra, rb, rw into internal regs; set gnt[winner]. No req -> stay IDLE.
//  EXEC: num_R1=ra_q, num_R2=rb_q, MS_out=op_q, W1=rw_q, WE=0; counter loads EXEC_CYCLES-1, leaves
//   when counter==0 (EXEC lasts exactly EXEC_CYCLES cycles).
//  WB: same addresses/MS_out held, WE=1 for exactly one cycle.
//  RESP: WE=0, MS_out=000, done[winner]=1 (or err[winner]=1 if illegal); ptr=(winner+1) mod N_REQ;
//   gnt cleared on exit. Next arbitration earliest in following IDLE cycle (no back-to-back accept).
//  Latency legal op: accept edge +EXEC_CYCLES+2 cycles to done pulse; illegal: done-free err next cycle.
//  Illegal op: 000, 101, 110, 111 -> no RF write, MS_out stays 000.
//  Only latched copies drive the bus; changes on op/ra/rb/rw after accept are ignored.
//  req dropped mid-operation: operation still completes and writes; done still pulses.
//  Simultaneous req from all: strict rotation, each served once before any repeats.
//  Requester whose req stays high after done competes again normally (rotation prevents starvation).
//  rw may equal ra/rb; read addresses held through WB so ALU output is stable during write.
//  gnt, done, err, busy and all bus outputs are registered (no combinational path from req).
// STRUCTURE
//  Shared package alu_pkg: ALU mode codes (MS_ADD..MS_XOR, MS_NOP), RF_IDLE_ADDR=3'b111, state enum.
//  One sub-module: rr_pick (combinational round-robin priority select: req, ptr -> winner idx, valid).
// TESTING
//  1. Reset: RSTn low mid-EXEC -> all outputs at idle values same cycle, busy=0, ptr=0.
//  2. req=01, op0=001, ra0=0, rb0=1, rw0=2 -> gnt=01, num_R1=0, num_R2=1, MS_out=001, WE=1 one cycle
//     with W1=2, done[0] pulse 3 cycles after accept (EXEC_CYCLES=1).
//  3. req=11 held continuously, ptr=0 -> grants alternate 0,1,0,1; no requester served twice in a row.
//  4. req=10, op1=110 -> err[1] one-cycle pulse, WE never 1, MS_out stays 000, done=00.
//  5. EXEC_CYCLES=4: op change on op0 during EXEC -> MS_out holds latched value 4 cycles; done at +6.
//  6. req0 dropped cycle after accept -> WB still writes, done[0] pulses, next IDLE grants nothing.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RF/ALU round-robin sequencer.
// Mode codes, idle bus address and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] MS_NOP = 3'b000;
  localparam logic [2:0] MS_ADD = 3'b001;
  localparam logic [2:0] MS_SUB = 3'b010;
  localparam logic [2:0] MS_MUL = 3'b011;
  localparam logic [2:0] MS_XOR = 3'b100;

  localparam logic [2:0] RF_IDLE_ADDR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  function automatic logic op_legal(
    input logic [2:0] code
  );
    return (code == MS_ADD) ||
           (code == MS_SUB) ||
           (code == MS_MUL) ||
           (code == MS_XOR);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin priority select.
// Winner is the first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [1:0]       idx_o,
  output logic             valid_o
);

  logic [3:0] req4;
  logic [1:0] j;

  assign req4 = 4'(req_i);

  // scan from ptr upward, first hit wins
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 2'd0;
    j       = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      j = 2'((int'(ptr_i) + i) % N_REQ);
      if (!valid_o && req4[j]) begin
        valid_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sequencer sharing one RF + ALU pair.
// Accepts one request, runs EXEC/WB, then reports.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] op,
  input  logic [3*N_REQ-1:0] ra,
  input  logic [3*N_REQ-1:0] rb,
  input  logic [3*N_REQ-1:0] rw,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               busy,
  output logic [2:0]         num_R1,
  output logic [2:0]         num_R2,
  output logic [2:0]         W1,
  output logic               WE,
  output logic [2:0]         MS_out
);

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [1:0]       win_q;
  logic [2:0]       cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic [N_REQ-1:0] err_q;
  logic             busy_q;
  logic [2:0]       r1_q;
  logic [2:0]       r2_q;
  logic [2:0]       w1_q;
  logic             we_q;
  logic [2:0]       ms_q;

  logic [1:0]       pick_idx;
  logic             pick_vld;
  logic [2:0]       sel_op;
  logic [2:0]       sel_ra;
  logic [2:0]       sel_rb;
  logic [2:0]       sel_rw;
  logic [N_REQ-1:0] onehot;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .valid_o(pick_vld)
  );

  // operand fields of the current arbitration winner
  always_comb begin
    sel_op = MS_NOP;
    sel_ra = RF_IDLE_ADDR;
    sel_rb = RF_IDLE_ADDR;
    sel_rw = RF_IDLE_ADDR;
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_op    = op[3*i +: 3];
        sel_ra    = ra[3*i +: 3];
        sel_rb    = rb[3*i +: 3];
        sel_rw    = rw[3*i +: 3];
        onehot[i] = 1'b1;
      end
    end
  end

  assign ptr_d = (win_q == 2'(N_REQ - 1)) ?
                 2'd0 : win_q + 2'd1;

  // sequencer FSM with registered bus and handshake outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      cnt_q   <= 3'd0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      r1_q    <= RF_IDLE_ADDR;
      r2_q    <= RF_IDLE_ADDR;
      w1_q    <= RF_IDLE_ADDR;
      we_q    <= 1'b0;
      ms_q    <= MS_NOP;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            win_q  <= pick_idx;
            gnt_q  <= onehot;
            busy_q <= 1'b1;
            cnt_q  <= 3'(EXEC_CYCLES - 1);
            if (op_legal(sel_op)) begin
              state_q <= S_EXEC;
              r1_q    <= sel_ra;
              r2_q    <= sel_rb;
              w1_q    <= sel_rw;
              ms_q    <= sel_op;
            end else begin
              state_q <= S_RESP;
              err_q   <= onehot;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 3'd0) begin
            state_q <= S_WB;
            we_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_WB: begin
          state_q <= S_RESP;
          we_q    <= 1'b0;
          ms_q    <= MS_NOP;
          r1_q    <= RF_IDLE_ADDR;
          r2_q    <= RF_IDLE_ADDR;
          w1_q    <= RF_IDLE_ADDR;
          done_q  <= gnt_q;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          err_q   <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign num_R1 = r1_q;
  assign num_R2 = r2_q;
  assign W1     = w1_q;
  assign WE     = we_q;
  assign MS_out = ms_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed steps plus
// randomized traffic against a transaction model.
module tb_alu_rr_arbiter;

  localparam int NA = 3;
  localparam int EA = 1;

  logic clk;
  logic rst_n;

  logic [NA-1:0]   reqA;
  logic [3*NA-1:0] opA, raA, rbA, rwA;
  logic [NA-1:0]   gntA, doneA, errA;
  logic            busyA, weA;
  logic [2:0]      r1A, r2A, w1A, msA;

  logic [1:0] reqB;
  logic [5:0] opB, raB, rbB, rwB;
  logic [1:0] gntB, doneB, errB;
  logic       busyB, weB;
  logic [2:0] r1B, r2B, w1B, msB;

  int tests;
  int fails;
  int ptr_m;
  int w;

  alu_rr_arbiter #(.N_REQ(NA), .EXEC_CYCLES(EA)) dut_a (
    .CLK(clk), .RSTn(rst_n),
    .req(reqA), .op(opA), .ra(raA), .rb(rbA), .rw(rwA),
    .gnt(gntA), .done(doneA), .err(errA), .busy(busyA),
    .num_R1(r1A), .num_R2(r2A), .W1(w1A), .WE(weA),
    .MS_out(msA)
  );

  alu_rr_arbiter #(.N_REQ(2), .EXEC_CYCLES(4)) dut_b (
    .CLK(clk), .RSTn(rst_n),
    .req(reqB), .op(opB), .ra(raB), .rb(rbB), .rw(rwB),
    .gnt(gntB), .done(doneB), .err(errB), .busy(busyB),
    .num_R1(r1B), .num_R2(r2B), .W1(w1B), .WE(weB),
    .MS_out(msB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] o,
                     input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
    end
  endtask

  function automatic int pick(input logic [NA-1:0] r,
                              input int p);
    for (int i = 0; i < NA; i++) begin
      if (r[(p + i) % NA]) return (p + i) % NA;
    end
    return -1;
  endfunction

  task automatic idle_a(input string tag);
    chk({tag, ".gnt"}, 32'(gntA), 0);
    chk({tag, ".done"}, 32'(doneA), 0);
    chk({tag, ".err"}, 32'(errA), 0);
    chk({tag, ".busy"}, 32'(busyA), 0);
    chk({tag, ".r1"}, 32'(r1A), 7);
    chk({tag, ".r2"}, 32'(r2A), 7);
    chk({tag, ".w1"}, 32'(w1A), 7);
    chk({tag, ".we"}, 32'(weA), 0);
    chk({tag, ".ms"}, 32'(msA), 0);
  endtask

  // one full transaction on instance A, starting at a
  // negedge in an IDLE cycle; returns the served index
  task automatic txn_a(input bit drop, output int wo);
    int wn;
    logic [2:0] o_, a_, b_, d_;
    logic [NA-1:0] oh;
    bit legal;
    wn = pick(reqA, ptr_m);
    wo = wn;
    if (wn < 0) begin
      @(posedge clk);
      @(negedge clk);
      chk("nogrant.busy", 32'(busyA), 0);
      chk("nogrant.gnt", 32'(gntA), 0);
      return;
    end
    o_ = opA[3*wn +: 3];
    a_ = raA[3*wn +: 3];
    b_ = rbA[3*wn +: 3];
    d_ = rwA[3*wn +: 3];
    oh = '0;
    oh[wn] = 1'b1;
    legal = (o_ >= 3'd1) && (o_ <= 3'd4);
    @(posedge clk);
    @(negedge clk);
    if (drop) reqA[wn] = 1'b0;
    opA[3*wn +: 3] = 3'($urandom);
    raA[3*wn +: 3] = 3'($urandom);
    rbA[3*wn +: 3] = 3'($urandom);
    rwA[3*wn +: 3] = 3'($urandom);
    if (legal) begin
      for (int e = 0; e < EA; e++) begin
        chk("exec.gnt", 32'(gntA), 32'(oh));
        chk("exec.busy", 32'(busyA), 1);
        chk("exec.r1", 32'(r1A), 32'(a_));
        chk("exec.r2", 32'(r2A), 32'(b_));
        chk("exec.ms", 32'(msA), 32'(o_));
        chk("exec.we", 32'(weA), 0);
        chk("exec.done", 32'(doneA), 0);
        @(negedge clk);
      end
      chk("wb.we", 32'(weA), 1);
      chk("wb.w1", 32'(w1A), 32'(d_));
      chk("wb.r1", 32'(r1A), 32'(a_));
      chk("wb.r2", 32'(r2A), 32'(b_));
      chk("wb.ms", 32'(msA), 32'(o_));
      chk("wb.done", 32'(doneA), 0);
      @(negedge clk);
      chk("resp.done", 32'(doneA), 32'(oh));
      chk("resp.err", 32'(errA), 0);
      chk("resp.we", 32'(weA), 0);
      chk("resp.ms", 32'(msA), 0);
      chk("resp.gnt", 32'(gntA), 32'(oh));
    end else begin
      chk("ill.err", 32'(errA), 32'(oh));
      chk("ill.done", 32'(doneA), 0);
      chk("ill.we", 32'(weA), 0);
      chk("ill.ms", 32'(msA), 0);
      chk("ill.gnt", 32'(gntA), 32'(oh));
      chk("ill.busy", 32'(busyA), 1);
    end
    @(negedge clk);
    chk("post.gnt", 32'(gntA), 0);
    chk("post.busy", 32'(busyA), 0);
    chk("post.done", 32'(doneA), 0);
    chk("post.err", 32'(errA), 0);
    ptr_m = (wn + 1) % NA;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ptr_m = 0;
    rst_n = 1'b0;
    reqA = '0; opA = '0; raA = '0; rbA = '0; rwA = '0;
    reqB = '0; opB = '0; raB = '0; rbB = '0; rwB = '0;
    repeat (3) @(negedge clk);
    idle_a("rst");
    chk("rstB.busy", 32'(busyB), 0);
    chk("rstB.ms", 32'(msB), 0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_a("idle");

    // basic add from requester 0
    reqA = 3'b001;
    opA[2:0] = 3'b001;
    raA[2:0] = 3'd0;
    rbA[2:0] = 3'd1;
    rwA[2:0] = 3'd2;
    txn_a(1'b0, w);
    chk("basic.winner", 32'(w), 0);
    reqA = '0;

    // illegal op from requester 1
    reqA = 3'b010;
    opA[5:3] = 3'b110;
    txn_a(1'b0, w);
    reqA = '0;
    idle_a("after_ill");

    // all requesting: strict rotation
    for (int i = 0; i < NA; i++) begin
      opA[3*i +: 3] = 3'(1 + (i % 4));
    end
    reqA = '1;
    for (int k = 0; k < 6; k++) begin
      txn_a(1'b0, w);
      opA[3*w +: 3] = 3'($urandom_range(1, 4));
    end
    reqA = '0;

    // req dropped right after accept
    @(negedge clk);
    ptr_m = 0;
    reqA = 3'b001;
    opA[2:0] = 3'b100;
    rwA[2:0] = 3'd6;
    txn_a(1'b1, w);
    chk("drop.req", 32'(reqA), 0);
    txn_a(1'b0, w);

    // async reset in the middle of EXEC
    reqA = '1;
    for (int i = 0; i < NA; i++) opA[3*i +: 3] = 3'b011;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst.busy", 32'(busyA), 1);
    rst_n = 1'b0;
    #1;
    idle_a("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    txn_a(1'b0, w);
    chk("rst.ptr", 32'(w), 0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NA; i++) begin
        if (!reqA[i] && $urandom_range(0, 1) == 1) begin
          reqA[i] = 1'b1;
          opA[3*i +: 3] = 3'($urandom_range(0, 7));
          raA[3*i +: 3] = 3'($urandom);
          rbA[3*i +: 3] = 3'($urandom);
          rwA[3*i +: 3] = 3'($urandom);
        end
      end
      txn_a($urandom_range(0, 3) == 0, w);
      if (w >= 0) begin
        if ($urandom_range(0, 1) == 1) reqA[w] = 1'b0;
        else opA[3*w +: 3] = 3'($urandom_range(0, 7));
      end
    end
    reqA = '0;
    @(negedge clk);
    @(negedge clk);

    // EXEC_CYCLES=4 instance: latched op, done at +6
    reqB = 2'b01;
    opB[2:0] = 3'b001;
    raB[2:0] = 3'd3;
    rbB[2:0] = 3'd4;
    rwB[2:0] = 3'd5;
    chk("b.idle", 32'(busyB), 0);
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) opB[2:0] = 3'b011;
      chk("b.exec.ms", 32'(msB), 1);
      chk("b.exec.we", 32'(weB), 0);
      chk("b.exec.r1", 32'(r1B), 3);
      chk("b.exec.done", 32'(doneB), 0);
    end
    @(negedge clk);
    chk("b.wb.we", 32'(weB), 1);
    chk("b.wb.w1", 32'(w1B), 5);
    chk("b.wb.ms", 32'(msB), 1);
    @(negedge clk);
    chk("b.resp.done", 32'(doneB), 1);
    chk("b.resp.gnt", 32'(gntB), 1);
    reqB = '0;
    @(negedge clk);
    chk("b.post.done", 32'(doneB), 0);
    chk("b.post.busy", 32'(busyB), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
